breakout_game_ctrl: RTL and testbench
=====================================

// Module: breakout_game_ctrl
// PURPOSE
//   Top-level game sequencer for the breakout text/graphics datapath.
//   - Four-state FSM: new game, play, new ball, game over.
//   - Owns the 2-digit BCD score (dig1:dig0) and the spare-ball count (ball)
//     that feed the text overlay.
//   - Drives the text-region enable mask and the graphics freeze (gra_still).
//   - Sits between the pixel-generation units and the button/graphics event sources.
// PARAMETERS
//   BALLS_INIT   3     spare balls loaded at reset and at every new game (0..3)
//   TIMER_TICKS  120   tick_60hz pulses the NEWBALL/OVER timer waits (2 s at 60 Hz), 1..127
// PORTS
//   clk        in   1  system clock, all state updates on rising edge
//   reset      in   1  asynchronous, active-high reset
//   btn        in   2  debounced paddle buttons, level; any bit high = "press"
//   tick_60hz  in   1  one-cycle pulse per video frame
//   hit        in   1  one-cycle pulse: ball hit a brick
//   miss       in   1  one-cycle pulse: ball left the playfield
//   dig0       out  4  score BCD units digit
//   dig1       out  4  score BCD tens digit
//   ball       out  2  spare balls remaining
//   text_sel   out  4  region enable mask {score,logo,rule,over}
//   gra_still  out  1  1 = graphics frozen (ball/paddle held)
//   game_state out  2  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER
// BEHAVIOUR
//   Reset (async, takes effect without clk): state NEWGAME, dig1=dig0=0,
//     ball=BALLS_INIT, timer=0, gra_still=1, text_sel=4'b1110.
//   Outputs:
//     - Moore outputs (text_sel, gra_still, game_state) decode the registered state.
//     - All outputs change 1 clk after the triggering edge; no combinational path from inputs.
//   Per-state outputs:
//     NEWGAME  text_sel=1110  gra_still=1
//     PLAY     text_sel=1100  gra_still=0
//     NEWBALL  text_sel=1100  gra_still=1
//     OVER     text_sel=1101  gra_still=1
//   Transitions:
//     NEWGAME -> PLAY    btn!=0
//     PLAY    -> OVER    miss && ball==0; load timer=TIMER_TICKS
//     PLAY    -> NEWBALL miss && ball!=0; ball<=ball-1; load timer=TIMER_TICKS
//     NEWBALL -> PLAY    timer==0 && btn!=0; btn during countdown is ignored (no latch)
//     OVER    -> NEWGAME timer==0; same edge clears dig1/dig0 to 0, ball<=BALLS_INIT
//   Timer (7 bit):
//     - Decrements by 1 on each tick_60hz while nonzero; holds at 0.
//     - A load overrides a tick in the same cycle.
//     - Ticks outside NEWBALL/OVER are ignored.
//   Score:
//     - hit is honoured only in PLAY; it increments the BCD pair (09->10, 19->20, ...).
//     - Saturates at 99; further hits leave 99.
//     - hit outside PLAY has no effect.
//   Simultaneous events:
//     - hit+miss in the same PLAY cycle applies both (score +1 and the miss transition).
//     - miss outside PLAY is ignored.
//   Score stays visible and unchanged through NEWBALL and OVER.
//   Reset mid-operation: any state/timer value returns to the reset values immediately;
//     the first post-reset edge behaves as NEWGAME.
// TESTING
//   1 reset, then btn=01 for 1 cycle -> next edge game_state=01, text_sel=1100, gra_still=0,
//     dig=00, ball=3
//   2 PLAY, 12 hit pulses -> dig1=1 dig0=2; 100 total hits -> dig1=9 dig0=9 (saturated)
//   3 PLAY ball=3, miss -> NEWBALL, ball=2; btn=11 held for 119 ticks -> stays NEWBALL;
//     after 120th tick -> PLAY
//   4 PLAY ball=0 score 37, miss -> OVER, text_sel=1101, dig=37 held;
//     120 ticks -> NEWGAME, dig=00, ball=3
//   5 PLAY ball=2 score 09, hit+miss same cycle -> dig=10, ball=1, NEWBALL;
//     hit in NEWBALL -> dig stays 10
//   6 reset pulsed between edges while in NEWBALL, timer=50 -> outputs at reset values
//     before the next clk edge

Source files
------------

// File: rtl/breakout_game_ctrl_if.sv
// Signal bundle between the breakout game sequencer and its event sources and
// text/graphics consumers.
interface breakout_game_ctrl_if;
  // No valid/ready handshake here: btn is a level, while tick_60hz, hit and
  // miss are single-cycle pulses sampled on the rising clock edge. Every
  // output is registered and is valid one clock after the edge that caused it.
  logic [1:0] btn;
  logic       tick_60hz;
  logic       hit;
  logic       miss;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [1:0] ball;
  logic [3:0] text_sel;
  logic       gra_still;
  logic [1:0] game_state;

  modport master (
    output btn, tick_60hz, hit, miss,
    input  dig0, dig1, ball, text_sel, gra_still, game_state
  );

  modport slave (
    input  btn, tick_60hz, hit, miss,
    output dig0, dig1, ball, text_sel, gra_still, game_state
  );
endinterface

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: four-state FSM that owns the BCD score, the
// spare-ball count and the NEWBALL/OVER countdown, and drives the overlay mask.
module breakout_game_ctrl #(
  parameter int unsigned BALLS_INIT  = 3,
  parameter int unsigned TIMER_TICKS = 120
) (
  input  logic                 clk,
  input  logic                 reset,
  breakout_game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_NEWGAME = 2'b00,
    S_PLAY    = 2'b01,
    S_NEWBALL = 2'b10,
    S_OVER    = 2'b11
  } state_t;

  localparam logic [1:0] BALLS_RST  = 2'(BALLS_INIT);
  localparam logic [6:0] TIMER_LOAD = 7'(TIMER_TICKS);

  state_t     state_q, state_d;
  logic [6:0] timer_q, timer_d;
  logic [3:0] dig0_q, dig0_d;
  logic [3:0] dig1_q, dig1_d;
  logic [1:0] ball_q, ball_d;
  logic [3:0] text_sel_q, text_sel_d;
  logic       gra_still_q, gra_still_d;
  logic       btn_press;

  assign btn_press = |bus.btn;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    dig0_d      = dig0_q;
    dig1_d      = dig1_q;
    ball_d      = ball_q;
    text_sel_d  = text_sel_q;
    gra_still_d = gra_still_q;

    // Countdown only runs while waiting; a load below overrides this decrement.
    if (((state_q == S_NEWBALL) || (state_q == S_OVER)) &&
        bus.tick_60hz && (timer_q != 7'd0)) begin
      timer_d = timer_q - 7'd1;
    end

    case (state_q)
      S_NEWGAME: begin
        if (btn_press) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (bus.hit && !((dig1_q == 4'd9) && (dig0_q == 4'd9))) begin
          if (dig0_q == 4'd9) begin
            dig0_d = 4'd0;
            dig1_d = dig1_q + 4'd1;
          end else begin
            dig0_d = dig0_q + 4'd1;
          end
        end
        if (bus.miss) begin
          timer_d = TIMER_LOAD;
          if (ball_q == 2'd0) begin
            state_d = S_OVER;
          end else begin
            state_d = S_NEWBALL;
            ball_d  = ball_q - 2'd1;
          end
        end
      end
      S_NEWBALL: begin
        if ((timer_q == 7'd0) && btn_press) state_d = S_PLAY;
      end
      S_OVER: begin
        if (timer_q == 7'd0) begin
          state_d = S_NEWGAME;
          dig0_d  = 4'd0;
          dig1_d  = 4'd0;
          ball_d  = BALLS_RST;
        end
      end
      default: state_d = S_NEWGAME;
    endcase

    // Moore outputs are decoded from the next state so they register alongside it.
    case (state_d)
      S_NEWGAME: begin text_sel_d = 4'b1110; gra_still_d = 1'b1; end
      S_PLAY:    begin text_sel_d = 4'b1100; gra_still_d = 1'b0; end
      S_NEWBALL: begin text_sel_d = 4'b1100; gra_still_d = 1'b1; end
      S_OVER:    begin text_sel_d = 4'b1101; gra_still_d = 1'b1; end
      default:   begin text_sel_d = 4'b1110; gra_still_d = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_NEWGAME;
      timer_q     <= 7'd0;
      dig0_q      <= 4'd0;
      dig1_q      <= 4'd0;
      ball_q      <= BALLS_RST;
      text_sel_q  <= 4'b1110;
      gra_still_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      dig0_q      <= dig0_d;
      dig1_q      <= dig1_d;
      ball_q      <= ball_d;
      text_sel_q  <= text_sel_d;
      gra_still_q <= gra_still_d;
    end
  end

  assign bus.dig0       = dig0_q;
  assign bus.dig1       = dig1_q;
  assign bus.ball       = ball_q;
  assign bus.text_sel   = text_sel_q;
  assign bus.gra_still  = gra_still_q;
  assign bus.game_state = state_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Self-checking bench for breakout_game_ctrl: a literal vector table, then
// scripted multi-cycle sequences scored against a small behavioural model.
module tb_breakout_game_ctrl;

  localparam int TT = 120;
  localparam int W  = 17;

  logic clk;
  logic reset;
  breakout_game_ctrl_if bus_if ();

  breakout_game_ctrl #(.BALLS_INIT(3), .TIMER_TICKS(TT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [W-1:0] exp_q[$];

  // behavioural model state
  int m_state, m_score, m_ball, m_timer;

  typedef struct {
    logic [1:0] btn;
    logic       tick;
    logic       hit;
    logic       miss;
    int         e_state;
    int         e_score;
    int         e_ball;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [W-1:0] exp_vec(input int st, input int sc, input int bl);
    logic [3:0] ts;
    logic       gs;
    case (st)
      0:       begin ts = 4'b1110; gs = 1'b1; end
      1:       begin ts = 4'b1100; gs = 1'b0; end
      2:       begin ts = 4'b1100; gs = 1'b1; end
      default: begin ts = 4'b1101; gs = 1'b1; end
    endcase
    return {2'(st), 4'(sc / 10), 4'(sc % 10), 2'(bl), ts, gs};
  endfunction

  function automatic logic [W-1:0] act_vec();
    return {bus_if.game_state, bus_if.dig1, bus_if.dig0, bus_if.ball,
            bus_if.text_sel, bus_if.gra_still};
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_ball = 3; m_timer = 0;
  endtask

  task automatic model_step(input logic [1:0] btn, input logic tick,
                            input logic hit, input logic miss);
    int ns, nsc, nb, nt;
    ns = m_state; nsc = m_score; nb = m_ball; nt = m_timer;
    if ((m_state == 2 || m_state == 3) && tick && m_timer > 0) nt = m_timer - 1;
    case (m_state)
      0: if (btn != 2'b00) ns = 1;
      1: begin
        if (hit && m_score < 99) nsc = m_score + 1;
        if (miss) begin
          nt = TT;
          if (m_ball == 0) ns = 3;
          else begin ns = 2; nb = m_ball - 1; end
        end
      end
      2: if (m_timer == 0 && btn != 2'b00) ns = 1;
      default: if (m_timer == 0) begin ns = 0; nsc = 0; nb = 3; end
    endcase
    m_state = ns; m_score = nsc; m_ball = nb; m_timer = nt;
  endtask

  task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got st=%0d dig=%0h%0h ball=%0d ts=%b gs=%b, want st=%0d dig=%0h%0h ball=%0d ts=%b gs=%b",
               name, act[16:15], act[14:11], act[10:7], act[6:5], act[4:1], act[0],
               exp[16:15], exp[14:11], exp[10:7], exp[6:5], exp[4:1], exp[0]);
    end
  endtask

  // driver: inputs set on the falling edge, result scored 1 ns after the rising edge
  task automatic apply(input string name, input logic [1:0] btn, input logic tick,
                       input logic hit, input logic miss, input bit lit,
                       input int ls, input int lsc, input int lb);
    @(negedge clk);
    bus_if.btn = btn; bus_if.tick_60hz = tick; bus_if.hit = hit; bus_if.miss = miss;
    model_step(btn, tick, hit, miss);
    if (lit) exp_q.push_back(exp_vec(ls, lsc, lb));
    else     exp_q.push_back(exp_vec(m_state, m_score, m_ball));
    @(posedge clk);
    #1;
    compare(name, act_vec(), exp_q.pop_front());
  endtask

  task automatic step(input string name, input logic [1:0] btn, input logic tick,
                      input logic hit, input logic miss);
    apply(name, btn, tick, hit, miss, 1'b0, 0, 0, 0);
  endtask

  task automatic repeat_step(input string name, input int n, input logic [1:0] btn,
                             input logic tick, input logic hit, input logic miss);
    for (int i = 0; i < n; i++) step(name, btn, tick, hit, miss);
  endtask

  task automatic check_lit(input string name, input int st, input int sc, input int bl);
    compare(name, act_vec(), exp_vec(st, sc, bl));
  endtask

  initial begin
    tbl[0]  = '{2'b00, 1'b0, 1'b0, 1'b0, 0, 0, 3};
    tbl[1]  = '{2'b00, 1'b1, 1'b1, 1'b1, 0, 0, 3};
    tbl[2]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1, 0, 3};
    tbl[3]  = '{2'b00, 1'b0, 1'b1, 1'b0, 1, 1, 3};
    tbl[4]  = '{2'b00, 1'b0, 1'b1, 1'b0, 1, 2, 3};
    tbl[5]  = '{2'b10, 1'b0, 1'b0, 1'b0, 1, 2, 3};
    tbl[6]  = '{2'b00, 1'b1, 1'b0, 1'b0, 1, 2, 3};
    tbl[7]  = '{2'b00, 1'b0, 1'b0, 1'b1, 2, 2, 2};
    tbl[8]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2, 2, 2};
    tbl[9]  = '{2'b00, 1'b0, 1'b0, 1'b1, 2, 2, 2};
    tbl[10] = '{2'b11, 1'b0, 1'b0, 1'b0, 2, 2, 2};

    bus_if.btn = 2'b00; bus_if.tick_60hz = 1'b0; bus_if.hit = 1'b0; bus_if.miss = 1'b0;
    reset = 1'b1;
    model_reset();
    #2;
    check_lit("reset_async", 0, 0, 3);
    repeat (2) @(posedge clk);
    #1;
    check_lit("reset_held", 0, 0, 3);
    @(negedge clk);
    reset = 1'b0;

    // literal vector table
    for (int i = 0; i < 11; i++) begin
      apply($sformatf("tbl%0d", i), tbl[i].btn, tbl[i].tick, tbl[i].hit, tbl[i].miss,
            1'b1, tbl[i].e_state, tbl[i].e_score, tbl[i].e_ball);
    end

    // NEWBALL countdown, buttons ignored until the timer expires
    repeat_step("nb_wait", TT - 1, 2'b11, 1'b1, 1'b0, 1'b0);
    check_lit("nb_119", 2, 2, 2);
    step("nb_tick120", 2'b11, 1'b1, 1'b0, 1'b0);
    check_lit("nb_120", 2, 2, 2);
    step("nb_go", 2'b11, 1'b0, 1'b0, 1'b0);
    check_lit("nb_play", 1, 2, 2);

    // score carry and saturation
    repeat_step("hits", 10, 2'b00, 1'b0, 1'b1, 1'b0);
    check_lit("score12", 1, 12, 2);
    repeat_step("hits_sat", 100, 2'b00, 1'b0, 1'b1, 1'b0);
    check_lit("score99", 1, 99, 2);

    // async reset between edges from NEWBALL with timer=50
    step("miss_nb", 2'b00, 1'b0, 1'b0, 1'b1);
    repeat_step("tick70", 70, 2'b00, 1'b1, 1'b0, 1'b0);
    check_lit("pre_reset", 2, 99, 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_lit("reset_mid", 0, 0, 3);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // hit+miss in one cycle, with a tick that the timer load must override
    step("start", 2'b01, 1'b0, 1'b0, 1'b0);
    repeat_step("hit9", 9, 2'b00, 1'b0, 1'b1, 1'b0);
    step("miss1", 2'b00, 1'b0, 1'b0, 1'b1);
    repeat_step("wait1", TT, 2'b00, 1'b1, 1'b0, 1'b0);
    step("resume1", 2'b01, 1'b0, 1'b0, 1'b0);
    check_lit("play_09", 1, 9, 2);
    step("hit_miss", 2'b00, 1'b1, 1'b1, 1'b1);
    check_lit("hm_10", 2, 10, 1);
    step("hit_nb", 2'b00, 1'b0, 1'b1, 1'b0);
    check_lit("hit_nb_10", 2, 10, 1);
    repeat_step("load_ovr", TT - 1, 2'b11, 1'b1, 1'b0, 1'b0);
    check_lit("load_ovr_hold", 2, 10, 1);
    step("last_tick", 2'b11, 1'b1, 1'b0, 1'b0);
    step("resume2", 2'b11, 1'b0, 1'b0, 1'b0);
    check_lit("play_10", 1, 10, 1);

    // last ball lost: OVER, then automatic return to NEWGAME
    repeat_step("hit27", 27, 2'b00, 1'b0, 1'b1, 1'b0);
    step("miss2", 2'b00, 1'b0, 1'b0, 1'b1);
    check_lit("nb_37", 2, 37, 0);
    repeat_step("wait2", TT, 2'b00, 1'b1, 1'b0, 1'b0);
    step("resume3", 2'b10, 1'b0, 1'b0, 1'b0);
    step("miss_last", 2'b00, 1'b0, 1'b0, 1'b1);
    check_lit("over_37", 3, 37, 0);
    step("hit_over", 2'b01, 1'b0, 1'b1, 1'b0);
    check_lit("over_hit", 3, 37, 0);
    repeat_step("over_wait", TT - 1, 2'b00, 1'b1, 1'b0, 1'b0);
    check_lit("over_119", 3, 37, 0);
    step("over_tick120", 2'b00, 1'b1, 1'b0, 1'b0);
    check_lit("over_120", 3, 37, 0);
    step("to_newgame", 2'b00, 1'b0, 1'b0, 1'b0);
    check_lit("newgame", 0, 0, 3);
    step("ng_miss", 2'b00, 1'b0, 1'b0, 1'b1);
    check_lit("ng_idle", 0, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
